// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio
// Purpose  : Memory-mapped front end for a byte UART core. A CPU writes
//            bytes into a TX FIFO and reads bytes out of an RX FIFO through
//            a simple valid/ready bus. A small drain FSM feeds the TX FIFO
//            into the UART core, honouring peer flow control (rts_n). The
//            block exports its own flow control (cts_n) from the RX fill.
//
// Ports    : clk, resetn             - clock, synchronous active-low reset
//            sel, mem_valid          - bus request qualifiers
//            mem_addr                - byte offset (0x0 DATA, 0x4 STATUS)
//            mem_wdata, mem_wstrb    - write data / strobes (0 strobes = read)
//            mem_ready, mem_rdata    - one-cycle completion pulse + read data
//            uart_transmit           - one-cycle start pulse to the UART core
//            uart_tx_byte            - byte presented to the UART core
//            uart_is_transmitting    - UART core busy
//            uart_received           - one-cycle byte-received strobe
//            uart_rx_byte            - received byte
//            uart_recv_error         - framing error, qualified by received
//            rts_n                   - peer ready to accept (0 = ready)
//            cts_n                   - this block ready to accept (0 = ready)
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio #(
    parameter int DEPTH            = 16,
    parameter int BASE_OFFSET_BITS = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        sel,
    input  logic                        mem_valid,
    input  logic [BASE_OFFSET_BITS-1:0] mem_addr,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_wstrb,
    output logic                        mem_ready,
    output logic [31:0]                 mem_rdata,
    output logic                        uart_transmit,
    output logic [7:0]                  uart_tx_byte,
    input  logic                        uart_is_transmitting,
    input  logic                        uart_received,
    input  logic [7:0]                  uart_rx_byte,
    input  logic                        uart_recv_error,
    input  logic                        rts_n,
    output logic                        cts_n
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero   = '0;
    localparam logic [c_cnt_w-1:0] c_full_cnt   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cts_thresh = c_cnt_w'(DEPTH - 2);

    localparam logic [BASE_OFFSET_BITS-1:0] c_addr_data   = BASE_OFFSET_BITS'(0);
    localparam logic [BASE_OFFSET_BITS-1:0] c_addr_status = BASE_OFFSET_BITS'(4);

    localparam logic [31:0] c_rx_empty_word = 32'h8000_0000;

    // TX drain FSM encoding
    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_start     = 2'd1;
    localparam logic [1:0] c_st_wait_busy = 2'd2;
    localparam logic [1:0] c_st_wait_done = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]         tx_mem_q [DEPTH];
    logic [c_ptr_w-1:0] tx_wr_ptr_q;
    logic [c_ptr_w-1:0] tx_rd_ptr_q;
    logic [c_cnt_w-1:0] tx_count_q;
    logic [c_cnt_w-1:0] tx_count_d;

    logic [7:0]         rx_mem_q [DEPTH];
    logic [c_ptr_w-1:0] rx_wr_ptr_q;
    logic [c_ptr_w-1:0] rx_rd_ptr_q;
    logic [c_cnt_w-1:0] rx_count_q;
    logic [c_cnt_w-1:0] rx_count_d;

    logic               overrun_q;
    logic               frame_err_q;

    logic [1:0]         tx_state_q;
    logic [1:0]         tx_state_d;

    logic               mem_ready_q;
    logic [31:0]        mem_rdata_q;
    logic               uart_transmit_q;
    logic [7:0]         uart_tx_byte_q;
    logic               cts_n_q;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic        w_req;
    logic        w_is_write;
    logic        w_addr_data;
    logic        w_addr_status;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_stall;
    logic        w_accept;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_set_overrun;
    logic        w_set_frame;
    logic        w_clr_overrun;
    logic        w_clr_frame;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused_wdata;

    // Upper write-data bits have no destination in this register map.
    assign w_unused_wdata = ^mem_wdata[31:8];

    // A new transaction is only seen while mem_ready is low, so the cycle
    // that completes a request can never also start a second one.
    assign w_req         = sel && mem_valid && !mem_ready_q;
    assign w_is_write    = (mem_wstrb != 4'b0000);
    assign w_addr_data   = (mem_addr == c_addr_data);
    assign w_addr_status = (mem_addr == c_addr_status);

    assign w_tx_full  = (tx_count_q == c_full_cnt);
    assign w_tx_empty = (tx_count_q == c_cnt_zero);
    assign w_rx_full  = (rx_count_q == c_full_cnt);
    assign w_rx_empty = (rx_count_q == c_cnt_zero);

    // Only a write that would actually push a byte waits for TX space; a
    // DATA write without strobe 0 has nothing to store and completes at once.
    // The request is re-evaluated every cycle, so once the drain FSM frees an
    // entry the push and the registered mem_ready happen on the same edge.
    assign w_stall  = w_req && w_is_write && w_addr_data && mem_wstrb[0] && w_tx_full;
    assign w_accept = w_req && !w_stall;

    assign w_tx_push = w_accept && w_is_write && w_addr_data && mem_wstrb[0];
    assign w_rx_pop  = w_accept && !w_is_write && w_addr_data && !w_rx_empty;

    // Overrun is judged on the count before this cycle's pop, so a byte
    // arriving at a full FIFO is dropped even if the CPU is reading.
    assign w_set_frame   = uart_received && uart_recv_error;
    assign w_set_overrun = uart_received && !uart_recv_error && w_rx_full;
    assign w_rx_push     = uart_received && !uart_recv_error && !w_rx_full;

    assign w_clr_overrun = w_accept && w_is_write && w_addr_status && mem_wdata[3];
    assign w_clr_frame   = w_accept && w_is_write && w_addr_status && mem_wdata[4];

    always_comb begin
        w_status       = '0;
        w_status[0]    = !w_rx_empty;
        w_status[1]    = w_tx_full;
        w_status[2]    = w_tx_empty;
        w_status[3]    = overrun_q;
        w_status[4]    = frame_err_q;
        w_status[15:8] = 8'(rx_count_q);
    end

    always_comb begin
        w_rdata = '0;
        if (!w_is_write) begin
            if (w_addr_data) begin
                w_rdata = w_rx_empty ? c_rx_empty_word : {24'h0, rx_mem_q[rx_rd_ptr_q]};
            end else if (w_addr_status) begin
                w_rdata = w_status;
            end
        end
    end

    // ------------------------------------------------------------------------
    // TX drain FSM
    // ------------------------------------------------------------------------
    // rts_n is only consulted in IDLE, so a peer that deasserts mid-byte
    // lets the current byte finish and merely holds off the next one.
    always_comb begin
        tx_state_d = tx_state_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            c_st_idle: begin
                if (!w_tx_empty && !uart_is_transmitting && !rts_n) begin
                    w_tx_pop   = 1'b1;
                    tx_state_d = c_st_start;
                end
            end
            c_st_start: begin
                tx_state_d = c_st_wait_busy;
            end
            c_st_wait_busy: begin
                if (uart_is_transmitting) begin
                    tx_state_d = c_st_wait_done;
                end
            end
            c_st_wait_done: begin
                if (!uart_is_transmitting) begin
                    tx_state_d = c_st_idle;
                end
            end
            default: begin
                tx_state_d = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO occupancy: a simultaneous push and pop leaves the count unchanged
    // ------------------------------------------------------------------------
    always_comb begin
        tx_count_d = tx_count_q;
        case ({w_tx_push, w_tx_pop})
            2'b10:   tx_count_d = tx_count_q + c_cnt_one;
            2'b01:   tx_count_d = tx_count_q - c_cnt_one;
            default: tx_count_d = tx_count_q;
        endcase
    end

    always_comb begin
        rx_count_d = rx_count_q;
        case ({w_rx_push, w_rx_pop})
            2'b10:   rx_count_d = rx_count_q + c_cnt_one;
            2'b01:   rx_count_d = rx_count_q - c_cnt_one;
            default: rx_count_d = rx_count_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO storage (contents need no reset; pointers and counts gate access)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= mem_wdata[7:0];
        end
        if (w_rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= uart_rx_byte;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_wr_ptr_q     <= '0;
            tx_rd_ptr_q     <= '0;
            tx_count_q      <= '0;
            rx_wr_ptr_q     <= '0;
            rx_rd_ptr_q     <= '0;
            rx_count_q      <= '0;
            overrun_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            tx_state_q      <= c_st_idle;
            mem_ready_q     <= 1'b0;
            mem_rdata_q     <= '0;
            uart_transmit_q <= 1'b0;
            uart_tx_byte_q  <= '0;
            cts_n_q         <= 1'b1;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
            if (w_tx_push) begin
                tx_wr_ptr_q <= tx_wr_ptr_q + c_ptr_one;
            end
            if (w_tx_pop) begin
                tx_rd_ptr_q <= tx_rd_ptr_q + c_ptr_one;
            end
            tx_count_q <= tx_count_d;

            if (w_rx_push) begin
                rx_wr_ptr_q <= rx_wr_ptr_q + c_ptr_one;
            end
            if (w_rx_pop) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + c_ptr_one;
            end
            rx_count_q <= rx_count_d;

            // A new error in the same cycle as its W1C keeps the flag set.
            if (w_set_overrun) begin
                overrun_q <= 1'b1;
            end else if (w_clr_overrun) begin
                overrun_q <= 1'b0;
            end
            if (w_set_frame) begin
                frame_err_q <= 1'b1;
            end else if (w_clr_frame) begin
                frame_err_q <= 1'b0;
            end

            tx_state_q <= tx_state_d;

            mem_ready_q <= w_accept;
            if (w_accept) begin
                mem_rdata_q <= w_rdata;
            end

            // The start pulse is high exactly while the FSM sits in START,
            // and the popped byte is held until the next pop.
            uart_transmit_q <= w_tx_pop;
            if (w_tx_pop) begin
                uart_tx_byte_q <= tx_mem_q[tx_rd_ptr_q];
            end

            // Built from the next count so cts_n tracks the live fill level.
            cts_n_q <= (rx_count_d >= c_cts_thresh);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_ready     = mem_ready_q;
    assign mem_rdata     = mem_rdata_q;
    assign uart_transmit = uart_transmit_q;
    assign uart_tx_byte  = uart_tx_byte_q;
    assign cts_n         = cts_n_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mmio
// Purpose  : Self-checking bench for uart_mmio. Stimulus pushes expected
//            bus read data and expected transmitted bytes into queues; a
//            monitor pops and compares on every mem_ready / uart_transmit.
//            A behavioural UART core answers each start pulse with a busy
//            window. Directed scenarios are followed by a randomised mix.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [AW-1:0] A_DATA   = 4'h0;
    localparam logic [AW-1:0] A_STATUS = 4'h4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          sel;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          uart_transmit;
    logic [7:0]    uart_tx_byte;
    logic          uart_is_transmitting;
    logic          uart_received;
    logic [7:0]    uart_rx_byte;
    logic          uart_recv_error;
    logic          rts_n;
    logic          cts_n;

    always #5 clk = ~clk;

    uart_mmio #(.DEPTH(DEPTH), .BASE_OFFSET_BITS(AW)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .sel                  (sel),
        .mem_valid            (mem_valid),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_wstrb            (mem_wstrb),
        .mem_ready            (mem_ready),
        .mem_rdata            (mem_rdata),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_received        (uart_received),
        .uart_rx_byte         (uart_rx_byte),
        .uart_recv_error      (uart_recv_error),
        .rts_n                (rts_n),
        .cts_n                (cts_n)
    );

    // Counters and scoreboard
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_rd_val[$];
    logic [31:0] exp_rd_mask[$];
    string       exp_rd_tag[$];
    logic [7:0]  exp_tx[$];

    // Reference model: RX FIFO contents and sticky flags
    logic [7:0]  rxq[$];
    bit          m_ovr = 1'b0;
    bit          m_frm = 1'b0;

    int          tx_seen    = 0;
    bit          mon_en     = 1'b0;
    int          core_delay = 1;
    bit          mon_prev_ready = 1'b0;
    bit          mon_prev_tx    = 1'b0;
    logic [31:0] mon_v;
    logic [31:0] mon_m;
    string       mon_t;

    function automatic void check(string tag, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endfunction

    function automatic void check1(string tag, logic act, logic exp);
        check(tag, {31'b0, act}, {31'b0, exp});
    endfunction

    function automatic void fail_now(string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s", msg);
    endfunction

    // STATUS as the model sees it; TX bits assume a drained TX FIFO and are
    // masked off by callers when that is not known.
    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (rxq.size() != 0);
        s[1]    = 1'b0;
        s[2]    = 1'b1;
        s[3]    = m_ovr;
        s[4]    = m_frm;
        s[15:8] = 8'(rxq.size());
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en || !resetn) begin
                mon_prev_ready = 1'b0;
                mon_prev_tx    = 1'b0;
            end else begin
                if (mon_prev_ready) check1("mem_ready_width", mem_ready, 1'b0);
                if (mon_prev_tx)    check1("uart_transmit_width", uart_transmit, 1'b0);
                if (mem_ready) begin
                    if (exp_rd_val.size() == 0) begin
                        fail_now($sformatf("unexpected_ready: got mem_ready=1 rdata 0x%08h, expected no transaction", mem_rdata));
                    end else begin
                        mon_v = exp_rd_val.pop_front();
                        mon_m = exp_rd_mask.pop_front();
                        mon_t = exp_rd_tag.pop_front();
                        check(mon_t, mem_rdata & mon_m, mon_v & mon_m);
                    end
                end
                if (uart_transmit) begin
                    tx_seen++;
                    if (exp_tx.size() == 0) begin
                        fail_now($sformatf("unexpected_tx: got byte 0x%02h, expected no transmission", uart_tx_byte));
                    end else begin
                        check("tx_byte", {24'h0, uart_tx_byte}, {24'h0, exp_tx.pop_front()});
                    end
                end
                mon_prev_ready = mem_ready;
                mon_prev_tx    = uart_transmit;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Behavioural UART core: busy window after each start pulse
    // ------------------------------------------------------------------------
    initial begin
        uart_is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_transmit) begin
                repeat (core_delay) @(posedge clk);
                @(posedge clk);
                #1 uart_is_transmitting = 1'b1;
                repeat ($urandom_range(3, 8)) @(posedge clk);
                #1 uart_is_transmitting = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers; every task returns 1 time unit after a rising edge
    // ------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] st,
                             input logic [31:0] ev, input logic [31:0] em, input string tag);
        exp_rd_val.push_back(ev);
        exp_rd_mask.push_back(em);
        exp_rd_tag.push_back(tag);
        sel       = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = st;
    endtask

    task automatic bus_wait(input int max, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (mem_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        sel       = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (!ok) begin
            fail_now($sformatf("%s_timeout: no mem_ready after %0d cycles, expected completion", tag, max));
            void'(exp_rd_val.pop_back());
            void'(exp_rd_mask.pop_back());
            void'(exp_rd_tag.pop_back());
        end
        cyc(1);
    endtask

    task automatic wr_data(input logic [7:0] b, input logic [3:0] st);
        if (st[0]) exp_tx.push_back(b);
        bus_start(A_DATA, {$urandom, b} >> 0, st, 32'h0, 32'h0, "data_write");
        mem_wdata = {24'($urandom), b};
        bus_wait(300, "data_write");
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] e;
        e = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h8000_0000;
        bus_start(A_DATA, 32'h0, 4'h0, e, 32'hFFFF_FFFF, tag);
        bus_wait(20, tag);
    endtask

    task automatic rd_status(input logic [31:0] mask, input string tag);
        bus_start(A_STATUS, 32'h0, 4'h0, model_status(), mask, tag);
        bus_wait(20, tag);
    endtask

    task automatic wr_status(input logic [31:0] w, input logic [3:0] st);
        if (w[3]) m_ovr = 1'b0;
        if (w[4]) m_frm = 1'b0;
        bus_start(A_STATUS, w, st, 32'h0, 32'h0, "status_write");
        bus_wait(20, "status_write");
    endtask

    task automatic rx_inject(input logic [7:0] b, input bit err);
        if (err)                      m_frm = 1'b1;
        else if (rxq.size() == DEPTH) m_ovr = 1'b1;
        else                          rxq.push_back(b);
        uart_received   = 1'b1;
        uart_rx_byte    = b;
        uart_recv_error = err;
        cyc(1);
        uart_received   = 1'b0;
        uart_recv_error = 1'b0;
    endtask

    task automatic wait_tx_drain(input int max);
        int quiet;
        bit ok;
        quiet = 0;
        ok    = 1'b0;
        for (int i = 0; i < max; i++) begin
            cyc(1);
            if (exp_tx.size() == 0 && !uart_is_transmitting) quiet++;
            else quiet = 0;
            if (quiet >= 24) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("tx_drain_timeout: %0d bytes still pending, expected 0", exp_tx.size()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_mem_ready"}, mem_ready, 1'b0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        check1({tag, "_uart_transmit"}, uart_transmit, 1'b0);
        check({tag, "_uart_tx_byte"}, {24'h0, uart_tx_byte}, 32'h0);
        check1({tag, "_cts_n"}, cts_n, 1'b1);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0]    b;
        logic [7:0]    nb;
        logic [31:0]   e;
        logic [AW-1:0] ua;
        int            seen0;

        resetn = 1'b0; sel = 1'b0; mem_valid = 1'b0; mem_addr = '0;
        mem_wdata = '0; mem_wstrb = '0; uart_received = 1'b0;
        uart_rx_byte = '0; uart_recv_error = 1'b0; rts_n = 1'b0;

        // Reset state and cts_n release
        @(posedge clk);
        cyc(3);
        check_reset_outputs("reset");
        resetn = 1'b1;
        cyc(1);
        check1("cts_n_after_release", cts_n, 1'b0);
        mon_en = 1'b1;

        // Two bytes with the peer ready
        rts_n = 1'b0;
        wr_data(8'h41, 4'b0001);
        wr_data(8'h42, 4'b0001);
        wait_tx_drain(400);
        rd_status(32'hFFFF_FFFF, "status_after_two_tx");

        // TX full stall released by rts_n
        rts_n = 1'b1;
        cyc(1);
        for (int i = 0; i < DEPTH; i++) wr_data(8'($urandom), 4'b0001);
        b = 8'($urandom);
        exp_tx.push_back(b);
        bus_start(A_DATA, {24'h0, b}, 4'b1111, 32'h0, 32'h0, "stalled_write");
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check1("stall_no_ready", mem_ready, 1'b0);
        end
        seen0 = tx_seen;
        rts_n = 1'b0;
        bus_wait(100, "stalled_write");
        check("stall_release_after_first_tx", 32'(tx_seen - seen0), 32'd1);
        wait_tx_drain(2000);
        rd_status(32'hFFFF_FFFF, "status_after_stall_drain");

        // RX fill, cts_n threshold and overrun
        for (int i = 0; i < DEPTH; i++) begin
            rx_inject(8'($urandom), 1'b0);
            cyc(1);
            check1($sformatf("cts_n_at_count_%0d", rxq.size()), cts_n, rxq.size() >= DEPTH - 2);
        end
        rx_inject(8'($urandom), 1'b0);
        rd_status(32'hFFFF_FFFF, "status_overrun");
        wr_status(32'h0000_0008, 4'b0001);
        rd_status(32'hFFFF_FFFF, "status_overrun_cleared");
        for (int i = 0; i < DEPTH; i++) rd_data("rx_drain");
        cyc(1);
        check1("cts_n_after_drain", cts_n, 1'b0);

        // Empty read and framing error
        rd_data("empty_read");
        rd_status(32'hFFFF_FFFF, "status_empty");
        rx_inject(8'($urandom), 1'b1);
        rd_status(32'hFFFF_FFFF, "status_frame_err");
        rd_data("empty_read_after_frame");
        wr_status(32'h0000_0010, 4'b0100);
        rd_status(32'hFFFF_FFFF, "status_frame_cleared");

        // Simultaneous RX push and DATA-read pop at count 5
        for (int i = 0; i < 5; i++) rx_inject(8'($urandom), 1'b0);
        e  = {24'h0, rxq.pop_front()};
        nb = 8'($urandom);
        rxq.push_back(nb);
        bus_start(A_DATA, 32'h0, 4'h0, e, 32'hFFFF_FFFF, "simul_pop");
        uart_received = 1'b1;
        uart_rx_byte  = nb;
        cyc(1);
        uart_received = 1'b0;
        bus_wait(20, "simul_pop");
        rd_status(32'hFFFF_FFFF, "status_count_5");
        for (int i = 0; i < 5; i++) rd_data("simul_order");

        // Reset while waiting for the core to go busy, three bytes queued
        core_delay = 15;
        rts_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) wr_data(8'($urandom), 4'b0001);
        seen0 = tx_seen;
        rts_n = 1'b0;
        for (int i = 0; i < 20 && tx_seen == seen0; i++) cyc(1);
        if (tx_seen == seen0) fail_now("wait_busy_setup: got no start pulse, expected one");
        cyc(2);
        resetn = 1'b0;
        exp_tx.delete();
        rxq.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
        cyc(1);
        check_reset_outputs("midbyte_reset");
        cyc(1);
        check1("midbyte_reset_transmit_low", uart_transmit, 1'b0);
        seen0 = tx_seen;
        resetn = 1'b1;
        cyc(1);
        check1("cts_n_after_midbyte_release", cts_n, 1'b0);
        cyc(80);
        check("no_tx_after_reset", 32'(tx_seen - seen0), 32'd0);
        rd_status(32'hFFFF_FFFF, "status_after_reset");
        rd_data("empty_read_after_reset");

        // Randomised mix
        core_delay = 1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    if (exp_tx.size() >= DEPTH) rts_n = 1'b0;
                    wr_data(8'($urandom), 4'($urandom_range(1, 15)));
                end
                3, 4:    rd_data("rand_data_read");
                5, 6:    rx_inject(8'($urandom), $urandom_range(0, 7) == 0);
                7:       rd_status(32'hFFFF_FFF9, "rand_status");
                8:       wr_status($urandom, 4'($urandom_range(1, 15)));
                default: begin
                    ua = 4'($urandom_range(1, 15));
                    if (ua == A_STATUS) ua = 4'h5;
                    if ($urandom_range(0, 1) == 1) begin
                        bus_start(ua, $urandom, 4'($urandom_range(1, 15)), 32'h0, 32'h0, "unmapped_write");
                        bus_wait(20, "unmapped_write");
                    end else begin
                        bus_start(ua, 32'h0, 4'h0, 32'h0, 32'hFFFF_FFFF, "unmapped_read");
                        bus_wait(20, "unmapped_read");
                    end
                end
            endcase
            if ($urandom_range(0, 3) == 0) rts_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) core_delay = $urandom_range(0, 3);
        end
        rts_n = 1'b0;
        wait_tx_drain(3000);
        rd_status(32'hFFFF_FFFF, "status_final");
        cyc(4);
        check("leftover_bus_expectations", 32'(exp_rd_val.size()), 32'd0);
        check("leftover_tx_expectations", 32'(exp_tx.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected sequence to complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, setting the entries per FIFO; DEPTH SHALL be a power of two, >= 4.
REQ-002 The block SHALL have parameter BASE_OFFSET_BITS, default 4, setting the width of mem_addr.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock (50 MHz domain)
- resetn  in  1  reset, synchronous, active-low
- sel  in  1  bus decoder selects this block
- mem_valid  in  1  CPU request valid
- mem_addr  in  BASE_OFFSET_BITS  byte offset within block
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 = read
- mem_ready  out  1  transaction complete pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- uart_transmit  out  1  one-cycle start pulse to UART core
- uart_tx_byte  out  8  byte to transmit
- uart_is_transmitting  in  1  UART core busy
- uart_received  in  1  one-cycle byte-received pulse
- uart_rx_byte  in  8  received byte
- uart_recv_error  in  1  framing error, qualified by uart_received
- rts_n  in  1  peer ready to accept (0 = ready)
- cts_n  out  1  this block ready to accept (0 = ready)

Function
REQ-004 The block SHALL start a bus transaction when sel && mem_valid && !mem_ready; mem_ready SHALL rise one cycle later (registered) and stay high for exactly one cycle, except for the TX-full stall (REQ-007).
REQ-005 The block SHALL decode these offsets:
- 0x0 DATA
- 0x4 STATUS
- any other offset: read returns 0x0000_0000, write is ignored, one-cycle ready.
REQ-006 A DATA write with mem_wstrb[0]=1 SHALL push mem_wdata[7:0] into the TX FIFO. A DATA write with mem_wstrb[0]=0 SHALL complete without a push.
REQ-007 A DATA write while the TX FIFO is full SHALL withhold mem_ready until an entry frees; the push and mem_ready SHALL then occur in the same cycle.
REQ-008 A DATA read of a non-empty RX FIFO SHALL return {24'h0, head byte} and pop that entry.
REQ-009 A DATA read of an empty RX FIFO SHALL return 0x8000_0000 and SHALL NOT pop.
REQ-010 A STATUS read SHALL return the following, with all other bits 0:
- bit0 rx_not_empty
- bit1 tx_full
- bit2 tx_empty
- bit3 overrun (sticky)
- bit4 frame_err (sticky)
- bits[15:8] rx_count, zero-extended
REQ-011 A STATUS write SHALL clear overrun where wdata[3]=1 and frame_err where wdata[4]=1 (W1C); all other bits SHALL be ignored.
REQ-012 The TX drain FSM SHALL run as follows:
- IDLE->START when TX FIFO non-empty && !uart_is_transmitting && !rts_n; on this transition, pop the head to uart_tx_byte.
- START: uart_transmit=1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY -> WAIT_DONE when uart_is_transmitting=1.
- WAIT_DONE -> IDLE when uart_is_transmitting=0.
REQ-013 uart_tx_byte SHALL hold its value from START until the next pop.
REQ-014 rts_n rising mid-byte SHALL NOT abort the current byte; it SHALL only block the next IDLE->START transition.
REQ-015 On uart_received=1, the RX path SHALL act as follows:
- uart_recv_error=1: set frame_err, discard byte.
- otherwise, RX FIFO full: set overrun, discard byte; this applies even if a pop occurs in the same cycle.
- otherwise: push the byte.
REQ-016 A simultaneous RX push and DATA-read pop SHALL leave rx_count unchanged, with both operations taking effect.
REQ-017 The same rule SHALL apply to the TX FIFO: a simultaneous push and pop SHALL leave the count unchanged.
REQ-018 FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; counts SHALL be log2(DEPTH)+1 bits in the range 0..DEPTH.
REQ-019 cts_n SHALL be a registered output: 1 when rx_count >= DEPTH-2, else 0.
REQ-020 A write with mem_wstrb!=0 SHALL be treated as a write regardless of which strobe bits are set.

Reset
REQ-021 While resetn=0 at a clk edge, the block SHALL set:
- FIFO pointers, counts, overrun and frame_err to 0
- TX FSM to IDLE
- mem_ready=0, mem_rdata=0
- uart_transmit=0, uart_tx_byte=0
- cts_n=1
REQ-022 Reset asserted mid-byte or mid-stall SHALL abandon the operation with no pending ready; after release, cts_n SHALL fall on the next cycle.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write 0x41, 0x42 to DATA with rts_n=0 -> two uart_transmit pulses carrying 0x41 then 0x42; STATUS bit2=1 afterwards.
- rts_n=1, write DEPTH+1 bytes -> the (DEPTH+1)th write stalls with no mem_ready; drop rts_n -> the first byte is sent and the stalled write then completes.
- Inject DEPTH received bytes, no reads -> cts_n=1 from count 14, DEPTH=16; the 17th byte sets STATUS bit3 and rx_count stays 16; write 0x08 to STATUS -> bit3 clears.
- Empty-RX DATA read -> 0x8000_0000, rx_count stays 0; a uart_received pulse with uart_recv_error=1 -> bit4 set, FIFO stays empty.
- RX count=5; DATA read pop and uart_received in the same cycle -> count stays 5 and the correct byte ordering is preserved.
- resetn=0 during WAIT_BUSY with 3 bytes queued -> all FIFOs empty, uart_transmit stays 0, and no further transmissions occur after release.
